capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_if.sv | 46 ++++
 rtl/capture_ctrl.sv | 145 ++++++++++++++
 tb/tb_capture_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/capture_if.sv
// capture_if: bundles the capture controller's control inputs and sample-RAM
// write outputs so the controller and its environment share one port.
//
// Signals (directions as seen from the slave, i.e. the controller):
//   run          in   capture-enable level from the config register
//   wrt_smpl     in   one-cycle strobe: a decimated sample is valid this cycle
//   triggered    in   sticky trigger flag from the trigger logic
//   trig_pos     in   number of post-trigger samples to keep
//   clr_cap_done in   host acknowledge pulse
//   we           out  sample RAM write enable
//   waddr        out  sample RAM write address
//   armed        out  enables the trigger logic
//   capture_done out  sticky capture-complete flag
//   run_clr      out  one-cycle pulse clearing the run bit
//   last_addr    out  address of the final sample written
//
// Handshake: there is no back-pressure. wrt_smpl is a strobe; when the
// controller is capturing, the sample is taken on the same cycle (we follows
// wrt_smpl combinationally) and waddr advances on the next rising clk edge.
// run_clr and clr_cap_done are single-cycle pulses; run, triggered and
// capture_done are levels.
interface capture_if #(
  parameter int AW = 9
);
  logic          run;
  logic          wrt_smpl;
  logic          triggered;
  logic [AW-1:0] trig_pos;
  logic          clr_cap_done;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          capture_done;
  logic          run_clr;
  logic [AW-1:0] last_addr;

  modport master (
    output run, wrt_smpl, triggered, trig_pos, clr_cap_done,
    input  we, waddr, armed, capture_done, run_clr, last_addr
  );

  modport slave (
    input  run, wrt_smpl, triggered, trig_pos, clr_cap_done,
    output we, waddr, armed, capture_done, run_clr, last_addr
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: logic-analyser capture controller. Writes decimated samples
// into a circular sample RAM, arms the trigger once enough pre-trigger history
// has been collected, keeps trig_pos post-trigger samples, then stops and
// reports the final write address so the dump can start at last_addr+1.
//
// Ports:
//   clk        in   system clock, all state updates on its rising edge
//   rst_n      in   asynchronous active-low reset
//   cap        capture_if.slave (see capture_if for signal list)
//   dbg_state  out  current FSM state (0 IDLE, 1 CAPTURE, 2 DONE)
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  capture_if.slave   cap,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [AW:0]   ENT_C    = (AW+1)'(ENTRIES);
  localparam logic [AW-1:0] TOP_ADDR = AW'(ENTRIES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] trig_cnt_q, trig_cnt_d;
  logic [AW:0]   smpl_q, smpl_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic          rclr_q, rclr_d;

  logic [AW-1:0] tp;
  logic [AW-1:0] waddr_inc, waddr_dec;
  logic [AW:0]   smpl_inc;
  logic          trig_hit, stop_now, final_wr, arm_hit, we_c;

  // Post-trigger depth can never exceed ENTRIES-1, otherwise the pre-trigger
  // window would be empty and the trigger could never arm.
  assign tp        = (cap.trig_pos > TOP_ADDR) ? TOP_ADDR : cap.trig_pos;
  assign waddr_inc = (waddr_q == TOP_ADDR) ? '0 : waddr_q + AW'(1);
  assign waddr_dec = (waddr_q == '0) ? TOP_ADDR : waddr_q - AW'(1);
  assign smpl_inc  = (smpl_q >= ENT_C) ? ENT_C : smpl_q + (AW+1)'(1);

  assign trig_hit  = armed_q && cap.triggered;
  // With zero post-trigger samples the capture ends on the trigger itself,
  // so the strobe in that cycle must not reach the RAM.
  assign stop_now  = trig_hit && (tp == '0);
  assign we_c      = (state_q == CAPTURE) && cap.wrt_smpl && !stop_now;
  // >= rather than == so a trig_pos lowered mid-capture still terminates.
  assign final_wr  = we_c && trig_hit && (tp != '0) &&
                     (({1'b0, trig_cnt_q} + (AW+1)'(1)) >= {1'b0, tp});
  assign arm_hit   = smpl_inc >= (ENT_C - {1'b0, tp});

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    last_d     = last_q;
    trig_cnt_d = trig_cnt_q;
    smpl_d     = smpl_q;
    armed_d    = armed_q;
    done_d     = done_q;
    rclr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cap.run && !done_q) begin
          state_d    = CAPTURE;
          smpl_d     = '0;
          trig_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end

      CAPTURE: begin
        if (we_c) begin
          waddr_d = waddr_inc;
          smpl_d  = smpl_inc;
          if (arm_hit) armed_d = 1'b1;
          if (trig_hit) trig_cnt_d = trig_cnt_q + AW'(1);
        end
        if (!cap.run) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (stop_now) begin
          state_d = DONE;
          done_d  = 1'b1;
          rclr_d  = 1'b1;
          last_d  = waddr_dec;
        end else if (final_wr) begin
          state_d = DONE;
          done_d  = 1'b1;
          rclr_d  = 1'b1;
          last_d  = waddr_q;
        end
      end

      DONE: begin
        if (cap.clr_cap_done) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      last_q     <= '0;
      trig_cnt_q <= '0;
      smpl_q     <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      rclr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      last_q     <= last_d;
      trig_cnt_q <= trig_cnt_d;
      smpl_q     <= smpl_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      rclr_q     <= rclr_d;
    end
  end

  assign cap.we           = we_c;
  assign cap.waddr        = waddr_q;
  assign cap.armed        = armed_q;
  assign cap.capture_done = done_q;
  assign cap.run_clr      = rclr_q;
  assign cap.last_addr    = last_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: self-checking bench for capture_ctrl with ENTRIES=8, AW=4.
module tb_capture_ctrl;
  localparam int ENTRIES = 8;
  localparam int AW      = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  capture_if #(.AW(AW)) cap ();

  capture_ctrl #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap       (cap),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int start_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] trig_pos;
    int            trig_after;  // triggered rises after this many writes
    int            arm_after;   // armed expected high after this many writes
    int            writes;      // total writes expected in the capture
    bit            clr_during;  // hold clr_cap_done high through capture
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, cap.we, 0);
    check({tag, "_waddr"}, cap.waddr, 0);
    check({tag, "_armed"}, cap.armed, 0);
    check({tag, "_done"}, cap.capture_done, 0);
    check({tag, "_run_clr"}, cap.run_clr, 0);
    check({tag, "_last_addr"}, cap.last_addr, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int nw = 0;
    int arm_at = -1;
    int rc = 0;
    int cyc = 0;
    bit fin = 0;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_last;
    for (int i = 0; i < v.writes; i++)
      exp_q.push_back(AW'((start_addr + i) % ENTRIES));
    exp_last = AW'((start_addr + v.writes - 1) % ENTRIES);

    @(negedge clk);
    cap.trig_pos     = v.trig_pos;
    cap.run          = 1'b1;
    cap.wrt_smpl     = 1'b0;
    cap.triggered    = 1'b0;
    cap.clr_cap_done = v.clr_during;
    @(posedge clk); #1;
    check("enter_capture", dbg_state, 1);

    while (!fin && cyc < 40) begin
      @(negedge clk);
      cap.triggered = (nw >= v.trig_after);
      cap.wrt_smpl  = 1'b1;
      #1;
      if (cap.we) begin
        if (exp_q.size() > 0) begin
          exp_addr = exp_q.pop_front();
          check("write_addr", cap.waddr, exp_addr);
        end
        nw++;
      end
      @(posedge clk); #1;
      if (cap.run_clr) rc++;
      if (cap.armed && arm_at < 0) arm_at = nw;
      if (cap.capture_done) fin = 1;
      cyc++;
    end

    check("capture_done", fin, 1);
    check("write_count", nw, v.writes);
    check("queue_drained", exp_q.size(), 0);
    check("armed_after", arm_at, v.arm_after);
    check("run_clr_pulse", rc, 1);
    check("last_addr", cap.last_addr, exp_last);
    check("waddr_after", cap.waddr, (start_addr + v.writes) % ENTRIES);
    exp_q.delete();

    @(negedge clk);
    cap.wrt_smpl     = 1'b0;
    cap.run          = 1'b0;
    cap.triggered    = 1'b0;
    cap.clr_cap_done = 1'b0;
    @(posedge clk); #1;
    check("run_clr_one_cycle", cap.run_clr, 0);
    check("done_state", dbg_state, 2);
    repeat (2) @(posedge clk);
    #1;
    check("done_held", cap.capture_done, 1);
    check("last_addr_held", cap.last_addr, exp_last);

    @(negedge clk);
    cap.clr_cap_done = 1'b1;
    @(posedge clk); #1;
    check("ack_clears_done", cap.capture_done, 0);
    check("ack_to_idle", dbg_state, 0);
    @(negedge clk);
    cap.clr_cap_done = 1'b0;
    start_addr = (start_addr + v.writes) % ENTRIES;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rc;
    logic [AW-1:0] exp_addr;
    vecs[0] = '{4'd4, 6, 4, 10, 1'b0};   // normal capture, post-trigger 6,7,0,1
    vecs[1] = '{4'd2, 0, 6, 8,  1'b0};   // trigger before armed
    vecs[2] = '{4'd0, 3, 8, 8,  1'b0};   // zero post-trigger samples
    vecs[3] = '{4'd9, 0, 1, 8,  1'b0};   // trig_pos clamps to 7
    vecs[4] = '{4'd7, 5, 1, 12, 1'b0};
    vecs[5] = '{4'd1, 10, 7, 11, 1'b1};  // ack held across the final edge

    cap.run          = 1'b0;
    cap.wrt_smpl     = 1'b0;
    cap.triggered    = 1'b0;
    cap.trig_pos     = '0;
    cap.clr_cap_done = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Abort: drop run after 3 writes.
    @(negedge clk);
    cap.trig_pos = 4'd7;
    cap.run      = 1'b1;
    @(posedge clk);
    rc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cap.wrt_smpl = 1'b1;
      #1;
      exp_addr = AW'((start_addr + i) % ENTRIES);
      check("abort_write_addr", cap.waddr, exp_addr);
      @(posedge clk); #1;
      if (cap.run_clr) rc++;
    end
    check("abort_armed_before", cap.armed, 1);
    @(negedge clk);
    cap.wrt_smpl = 1'b0;
    cap.run      = 1'b0;
    @(posedge clk); #1;
    if (cap.run_clr) rc++;
    check("abort_state", dbg_state, 0);
    check("abort_we", cap.we, 0);
    check("abort_armed", cap.armed, 0);
    check("abort_done", cap.capture_done, 0);
    check("abort_waddr", cap.waddr, (start_addr + 3) % ENTRIES);
    repeat (3) begin
      @(posedge clk); #1;
      if (cap.run_clr) rc++;
    end
    check("abort_no_run_clr", rc, 0);
    start_addr = (start_addr + 3) % ENTRIES;

    // Reset asserted mid-capture between clock edges.
    @(negedge clk);
    cap.trig_pos = 4'd3;
    cap.run      = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      cap.wrt_smpl = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    cap.run      = 1'b0;
    cap.wrt_smpl = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    check("post_reset_run_clr", cap.run_clr, 0);
    check("post_reset_state", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
